// File: rtl/pclk_rate_switch.sv
// Selectable-rate clock-enable generator with a hitless rate switch: the old
// period always runs to completion and a fixed idle gap precedes the new cadence.
module pclk_rate_switch #(
    parameter int NUM_RATES  = 4,
    parameter int RW         = ($clog2(NUM_RATES) > 1) ? $clog2(NUM_RATES) : 1,
    parameter int GAP_CYCLES = 2,
    parameter int RESET_RATE = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rate_req_valid,
    input  logic [RW-1:0] rate_req,
    output logic          rate_req_ready,
    output logic          rate_ack,
    output logic          rate_err,
    output logic [RW-1:0] rate_cur,
    output logic          pclk_en,
    output logic          busy
);

    localparam int CW = NUM_RATES - 1;
    localparam int GW = 4;
    localparam logic [RW:0]   NUM_RATES_W  = (RW + 1)'(NUM_RATES);
    localparam logic [RW-1:0] RESET_RATE_W = RW'(RESET_RATE);
    localparam logic [GW-1:0] GAP_LAST_W   = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s, last_s;
    logic [CW:0]   span_s;
    logic [GW-1:0] gap_cnt_r, gap_cnt_s;
    logic [RW-1:0] rate_cur_r, rate_cur_s, target_r, target_s;
    logic          ack_r, ack_s, err_r, err_s;
    logic          period_end_s;

    // Last count value of the active period (2^rate - 1) and the wrapping increment.
    always_comb begin
        span_s       = {{CW{1'b0}}, 1'b1} << rate_cur_r;
        last_s       = span_s[CW-1:0] - CW'(1);
        period_end_s = (cnt_r == last_s);
        if (period_end_s) begin
            cnt_inc_s = {CW{1'b0}};
        end else begin
            cnt_inc_s = cnt_r + CW'(1);
        end
    end

    // Next-state, period counter, rate latch and one-cycle status pulses.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_inc_s;
        gap_cnt_s  = gap_cnt_r;
        rate_cur_s = rate_cur_r;
        target_s   = target_r;
        ack_s      = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (rate_req_valid) begin
                    if ({1'b0, rate_req} >= NUM_RATES_W) begin
                        err_s = 1'b1;
                    end else if (rate_req == rate_cur_r) begin
                        ack_s = 1'b1;
                    end else begin
                        target_s = rate_req;
                        state_s  = ST_DRAIN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // The old period finishes before anything changes.
                if (period_end_s) begin
                    cnt_s = {CW{1'b0}};
                    if (GAP_CYCLES == 0) begin
                        state_s    = ST_RUN;
                        rate_cur_s = target_r;
                        ack_s      = 1'b1;
                    end else begin
                        state_s   = ST_GAP;
                        gap_cnt_s = {GW{1'b0}};
                    end
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_GAP: begin
                cnt_s = {CW{1'b0}};
                if (gap_cnt_r == GAP_LAST_W) begin
                    state_s    = ST_RUN;
                    rate_cur_s = target_r;
                    ack_s      = 1'b1;
                    gap_cnt_s  = {GW{1'b0}};
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RUN;
            cnt_r      <= {CW{1'b0}};
            gap_cnt_r  <= {GW{1'b0}};
            rate_cur_r <= RESET_RATE_W;
            target_r   <= {RW{1'b0}};
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            rate_cur_r <= rate_cur_s;
            target_r   <= target_s;
            ack_r      <= ack_s;
            err_r      <= err_s;
        end
    end

    // Outputs are forced quiet during the reset cycle itself, not only after it.
    assign rate_req_ready = (state_r == ST_RUN) && !rst;
    assign pclk_en        = (state_r != ST_GAP) && (cnt_r == {CW{1'b0}}) && !rst;
    assign busy           = (state_r != ST_RUN) && !rst;
    assign rate_ack       = ack_r && !rst;
    assign rate_err       = err_r && !rst;
    assign rate_cur       = rst ? RESET_RATE_W : rate_cur_r;

endmodule

// File: tb/tb_pclk_rate_switch.sv
// Scoreboard bench for pclk_rate_switch: directed switch scenarios plus random
// requests and resets, compared against an arithmetic schedule model.
`timescale 1ns/1ps
module tb_pclk_rate_switch;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rate_req_valid = 1'b0;
    logic [1:0] rate_req = 2'd0;
    logic       rate_req_ready, rate_ack, rate_err, pclk_en, busy;
    logic [1:0] rate_cur;

    logic       rst3 = 1'b1;
    logic       v3 = 1'b0;
    logic [1:0] rr3 = 2'd0;
    logic       rdy3, ack3, err3, en3, busy3;
    logic [1:0] cur3;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int cyc;
        int rate;
    } exp_t;
    exp_t q[$];

    int m_rate = 0, m_anchor = 0, m_target = 0;
    int m_busy_from = 0, m_gap_start = 0, m_act = 0;
    bit m_pending = 1'b0;

    pclk_rate_switch #(.NUM_RATES(4), .GAP_CYCLES(GAP), .RESET_RATE(0)) u_dut (
        .clk(clk), .rst(rst), .rate_req_valid(rate_req_valid), .rate_req(rate_req),
        .rate_req_ready(rate_req_ready), .rate_ack(rate_ack), .rate_err(rate_err),
        .rate_cur(rate_cur), .pclk_en(pclk_en), .busy(busy)
    );

    pclk_rate_switch #(.NUM_RATES(3), .GAP_CYCLES(GAP), .RESET_RATE(0)) u_dut3 (
        .clk(clk), .rst(rst3), .rate_req_valid(v3), .rate_req(rr3),
        .rate_req_ready(rdy3), .rate_ack(ack3), .rate_err(err3),
        .rate_cur(cur3), .pclk_en(en3), .busy(busy3)
    );

    always #5 clk = ~clk;

    // Cycle index; inputs change at posedge+1, outputs are sampled at negedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // One clock cycle of main-instance stimulus; accepted requests schedule their ack.
    task automatic do_cycle(input bit v, input int r, input bit rs);
        int per, p, k;
        @(posedge clk);
        #1;
        if (rst && !rs) m_anchor = cyc;
        rst = rs;
        if (rs) begin
            m_pending = 1'b0;
            m_rate    = 0;
            q.delete();
        end else if (m_pending && cyc >= m_act) begin
            m_rate    = m_target;
            m_anchor  = m_act;
            m_pending = 1'b0;
        end
        rate_req_valid = v;
        rate_req       = 2'(r);
        if (v && !rs && !(m_pending && cyc >= m_busy_from)) begin
            if (r == m_rate) begin
                q.push_back('{cyc + 1, r});
            end else begin
                // Old period runs out (at least one drain cycle), then the gap.
                per = 1 << m_rate;
                p   = (cyc - m_anchor) % per;
                k   = ((per - 2 - p + per) % per) + 1;
                m_pending   = 1'b1;
                m_target    = r;
                m_busy_from = cyc + 1;
                m_gap_start = cyc + k + 1;
                m_act       = m_gap_start + GAP;
                q.push_back('{m_act, r});
            end
        end
    endtask

    // Monitor: compare the main instance with the model every cycle; acks pop the scoreboard.
    always @(negedge clk) begin : mon
        exp_t e;
        bit   busy_e;
        bit   en_e;
        if (rst) begin
            chk("rst_pclk_en", int'(pclk_en), 0);
            chk("rst_rate_cur", int'(rate_cur), 0);
            chk("rst_ready_busy_ack_err", int'({rate_req_ready, busy, rate_ack, rate_err}), 0);
        end else begin
            busy_e = m_pending && (cyc >= m_busy_from);
            if (m_pending && cyc >= m_gap_start) en_e = 1'b0;
            else en_e = (((cyc - m_anchor) % (1 << m_rate)) == 0);
            chk("pclk_en", int'(pclk_en), int'(en_e));
            chk("busy", int'(busy), int'(busy_e));
            chk("ready", int'(rate_req_ready), int'(!busy_e));
            chk("rate_cur", int'(rate_cur), m_rate);
            chk("rate_err", int'(rate_err), 0);
            if (rate_ack) begin
                if (q.size() == 0) begin
                    chk("ack_expected", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_rate", int'(rate_cur), e.rate);
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                chk("ack_pulse", int'(rate_ack), 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin : stim
        bit got;
        repeat (3) do_cycle(1'b0, 0, 1'b1);
        repeat (6) do_cycle(1'b0, 0, 1'b0);
        // 0 -> 2 switch, then a same-rate request at rate 2.
        do_cycle(1'b1, 2, 1'b0);
        repeat (16) do_cycle(1'b0, 0, 1'b0);
        do_cycle(1'b1, 2, 1'b0);
        repeat (10) do_cycle(1'b0, 0, 1'b0);
        // 2 -> 1 switch issued when the period counter sits at 1.
        for (int i = 0; i < 16; i++) begin
            if (!m_pending && m_rate == 2 && ((cyc + 1 - m_anchor) % 4) == 1) break;
            do_cycle(1'b0, 0, 1'b0);
        end
        do_cycle(1'b1, 1, 1'b0);
        repeat (12) do_cycle(1'b0, 0, 1'b0);
        // 0 -> 3 switch aborted by reset during the gap.
        do_cycle(1'b0, 0, 1'b1);
        do_cycle(1'b1, 3, 1'b0);
        do_cycle(1'b0, 0, 1'b0);
        do_cycle(1'b0, 0, 1'b1);
        repeat (20) do_cycle(1'b0, 0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            do_cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                     $urandom_range(0, 199) == 0);
        end
        repeat (30) do_cycle(1'b0, 0, 1'b0);

        // Three-rate instance: move to rate 1, then reject an out-of-range request.
        do_cycle(1'b0, 0, 1'b0);
        rst3 = 1'b0;
        v3   = 1'b1;
        rr3  = 2'd1;
        got  = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            do_cycle(1'b0, 0, 1'b0);
            v3 = 1'b0;
            @(negedge clk);
            if (ack3) got = 1'b1;
        end
        chk("u3_ack_seen", int'(got), 1);
        chk("u3_rate_after_ack", int'(cur3), 1);
        chk("u3_en_at_ack", int'(en3), 1);
        repeat (2) do_cycle(1'b0, 0, 1'b0);
        do_cycle(1'b0, 0, 1'b0);
        v3  = 1'b1;
        rr3 = 2'd3;
        @(negedge clk);
        chk("u3_ready", int'(rdy3), 1);
        chk("u3_en_odd", int'(en3), 0);
        do_cycle(1'b0, 0, 1'b0);
        v3 = 1'b0;
        @(negedge clk);
        chk("u3_err_pulse", int'(err3), 1);
        chk("u3_no_ack", int'(ack3), 0);
        chk("u3_rate_kept", int'(cur3), 1);
        chk("u3_en_even", int'(en3), 1);
        chk("u3_not_busy", int'(busy3), 0);
        do_cycle(1'b0, 0, 1'b0);
        @(negedge clk);
        chk("u3_err_one_cycle", int'(err3), 0);
        chk("u3_en_odd2", int'(en3), 0);
        do_cycle(1'b0, 0, 1'b0);
        @(negedge clk);
        chk("u3_en_even2", int'(en3), 1);
        chk("u3_rate_final", int'(cur3), 1);

        chk("ack_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pclk_rate_switch.md
PCLK_RATE_SWITCH -- requirements
Module: pclk_rate_switch

Interface
REQ-001 Parameter NUM_RATES, 4, number of selectable rates (legal 2..8); rate r produces a strobe every 2^r clk cycles.
REQ-002 Parameter RW, max(1,clog2(NUM_RATES)), width of rate fields.
REQ-003 Parameter GAP_CYCLES, 2, forced-idle cycles between the last old-rate period and the first new-rate strobe (legal 0..15).
REQ-004 Parameter RESET_RATE, 0, rate selected after reset (must be < NUM_RATES).
REQ-005 One clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  input  1  single block clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 rate_req_valid  input  1  rate-change request present.
REQ-009 rate_req  input  RW  requested rate index.
REQ-010 rate_req_ready  output  1  request accepted this cycle when high with rate_req_valid.
REQ-011 rate_ack  output  1  one-cycle pulse: requested rate is now active.
REQ-012 rate_err  output  1  one-cycle pulse: request rejected (rate_req >= NUM_RATES).
REQ-013 rate_cur  output  RW  currently active rate index.
REQ-014 pclk_en  output  1  clock-enable strobe, one cycle high per divided period.
REQ-015 busy  output  1  high whenever state is not RUN.

Function
REQ-016 States SHALL be RUN, DRAIN, GAP; period counter cnt SHALL be NUM_RATES-1 bits, last value L = 2^rate_cur - 1.
REQ-017 In RUN and DRAIN, cnt SHALL increment each cycle and wrap L -> 0; pclk_en SHALL equal (cnt == 0), decoded from registers.
REQ-018 In GAP, pclk_en SHALL be 0 and cnt SHALL hold 0.
REQ-019 rate_req_ready SHALL be 1 only in RUN and rst low; valid while not ready SHALL be ignored, not queued.
REQ-020 Accepted request (cycle T) with rate_req >= NUM_RATES: rate_err=1 at T+1, no state or rate change, no ack.
REQ-021 Accepted request with rate_req == rate_cur: rate_ack=1 at T+1, stay RUN, cnt and strobe cadence undisturbed.
REQ-022 Accepted request with a different legal rate: latch target, enter DRAIN at T+1.
REQ-023 DRAIN: old-rate strobes continue; in the DRAIN cycle where cnt == L, next state SHALL be GAP (or RUN directly if GAP_CYCLES == 0).
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, then RUN.
REQ-025 Entering RUN from DRAIN/GAP: rate_cur = target, cnt = 0; in that first RUN cycle pclk_en=1 and rate_ack=1.
REQ-026 Guarantee: no pclk_en strobe SHALL ever be closer than min(old,new) period to its predecessor; no truncated old-rate period.
REQ-027 rate_ack and rate_err SHALL never be high in the same cycle; each SHALL be exactly one cycle wide.

Reset
REQ-028 While rst high: state RUN, rate_cur=RESET_RATE, cnt=0, target cleared, pclk_en=0, rate_ack=0, rate_err=0, busy=0, rate_req_ready=0.
REQ-029 First cycle after rst falls: pclk_en=1, rate_req_ready=1.
REQ-030 rst asserted in DRAIN or GAP SHALL abort the switch: no rate_ack, rate_cur=RESET_RATE.

Verification (NUM_RATES=4, GAP_CYCLES=2, RESET_RATE=0 unless noted)
REQ-031 rst high 3 cycles -> pclk_en=0, rate_cur=0 during reset; after release pclk_en=1 every cycle, busy=0, ready=1.
REQ-032 At rate 0, request 2 accepted at T -> DRAIN T+1 (strobe), GAP T+2..T+3 (pclk_en=0, busy=1), RUN T+4 with pclk_en=1 and rate_ack=1, then strobes T+8, T+12.
REQ-033 At rate 2, request 1 accepted at T with cnt=1 -> strobes none at T+1..T+2, GAP T+3..T+4, RUN T+5 pclk_en=1 and ack, then strobes every 2 cycles.
REQ-034 At rate 2, request 2 -> rate_ack at T+1, busy stays 0, strobe every 4 cycles unbroken.
REQ-035 NUM_RATES=3, request 3 -> rate_err=1 at T+1 only, rate_cur unchanged, no ack, cadence unchanged.
REQ-036 Switch 0->3 with rst pulsed during GAP -> next cycle rate_cur=0, RUN, busy=0, no rate_ack ever issued for that request.
